// File: rtl/memory_access_stage_pkg.sv
// Shared types for the memory access pipeline stage: access sizes, FSM states,
// and the writeback payload structs. Optional trap: MEM_ACCESS_MISALIGN_TRAP_EN.
package memory_access_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_RESP = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic             wEnable;
    logic [REG_W-1:0] rdAddr;
  } RD_CTRL;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] r_data;
    logic              is_load;
    RD_CTRL            rdCtrl;
  } MEMORY_ACCESS_STAGE;

  // Half must be 2-byte aligned, word 4-byte aligned; the reserved size
  // encoding is handled as a word.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
    case (size)
      MEM_BYTE: is_misaligned = 1'b0;
      MEM_HALF: is_misaligned = off[0];
      default:  is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/memory_access_stage_lane_align.sv
// Combinational byte-lane logic: store replication and byte enables, plus
// load-lane extraction with sign/zero extension.
module mem_lane_align
  import memory_access_stage_pkg::*;
(
  input  mem_size_t          i_size,
  input  logic [1:0]         i_off,
  input  logic               i_unsigned,
  input  logic [DATA_W-1:0]  i_store_data,
  input  logic [DATA_W-1:0]  i_rdata,
  output logic [3:0]         o_be,
  output logic [DATA_W-1:0]  o_wdata,
  output logic [DATA_W-1:0]  o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halfword lane selection uses only off[1]; off[0] is ignored so a
  // misaligned half still lands on a legal lane pair.
  assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
  assign w_half = i_rdata[{i_off[1], 4'b0000} +: 16];

  always_comb begin
    o_be        = 4'b1111;
    o_wdata     = i_store_data;
    o_load_data = i_rdata;
    case (i_size)
      MEM_BYTE: begin
        o_be        = 4'b0001 << i_off;
        o_wdata     = {4{i_store_data[7:0]}};
        o_load_data = i_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      MEM_HALF: begin
        o_be        = i_off[1] ? 4'b1100 : 4'b0011;
        o_wdata     = {2{i_store_data[15:0]}};
        o_load_data = i_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      end
      default: begin
        o_be        = 4'b1111;
        o_wdata     = i_store_data;
        o_load_data = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// Memory access stage: one dmem transaction per load/store, result registered
// for writeback. Optional misaligned-access trap: MEM_ACCESS_MISALIGN_TRAP_EN.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [XLEN-1:0]       ex_pc,
  input  logic [XLEN-1:0]       ex_alu_result,
  input  logic [XLEN-1:0]       ex_store_data,
  input  logic                  ex_is_load,
  input  logic                  ex_is_store,
  input  logic [1:0]            ex_mem_size,
  input  logic                  ex_mem_unsigned,
  input  logic                  ex_rd_wen,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  stall_out,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_ready,
  input  logic                  dmem_rvalid,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  wb_valid,
  output logic [XLEN-1:0]       wb_pc,
  output logic [XLEN-1:0]       wb_alu_result,
  output logic [XLEN-1:0]       wb_r_data,
  output logic                  wb_is_load,
  output logic                  wb_rd_wen,
  output logic [REG_ADDR_W-1:0] wb_rd_addr,
  output logic                  wb_misaligned,
  output logic [1:0]            dbg_state
);

  // dmem handshake: a request is transferred on a cycle where dmem_req and
  // dmem_ready are both high; address/we/be/wdata hold until then. Load data
  // is taken on any cycle dmem_rvalid is high while a load is outstanding.

  mem_state_t         r_state;
  MEMORY_ACCESS_STAGE r_wb;
  logic               r_wb_valid;
  logic               r_wb_misaligned;

  mem_size_t          w_size;
  logic               w_is_mem;
  logic               w_trap;
  logic               w_start_mem;
  logic               w_done_alu;
  logic               w_done_store;
  logic               w_done_load;
  logic               w_done;
  logic [3:0]         w_be;
  logic [XLEN-1:0]    w_wdata;
  logic [XLEN-1:0]    w_load_data;

  assign w_size   = mem_size_t'(ex_mem_size);
  assign w_is_mem = ex_is_load | ex_is_store;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign w_trap = w_is_mem & is_misaligned(w_size, ex_alu_result[1:0]);
`else
  assign w_trap = 1'b0;
`endif

  mem_lane_align u_align (
    .i_size       (w_size),
    .i_off        (ex_alu_result[1:0]),
    .i_unsigned   (ex_mem_unsigned),
    .i_store_data (ex_store_data),
    .i_rdata      (dmem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data)
  );

  assign w_start_mem  = (r_state == ST_IDLE) & ex_valid & w_is_mem & ~w_trap;
  assign w_done_alu   = (r_state == ST_IDLE) & ex_valid & (~w_is_mem | w_trap);
  assign w_done_store = (r_state == ST_REQ) & dmem_ready & ~ex_is_load;
  // Zero-wait memory: ready and rvalid together finish the load from REQ.
  assign w_done_load  = ((r_state == ST_REQ) & dmem_ready & dmem_rvalid & ex_is_load)
                      | ((r_state == ST_WAIT_RESP) & dmem_rvalid);
  assign w_done       = w_done_alu | w_done_store | w_done_load;

  // Stall releases in the completion cycle so execute advances at that edge.
  assign stall_out = ~rst & (w_start_mem
                   | ((r_state == ST_REQ) & ~(w_done_store | w_done_load))
                   | ((r_state == ST_WAIT_RESP) & ~dmem_rvalid));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_wb            <= '0;
      r_wb_valid      <= 1'b0;
      r_wb_misaligned <= 1'b0;
    end else begin
      r_wb_valid            <= 1'b0;
      r_wb.rdCtrl.wEnable   <= 1'b0;
      case (r_state)
        ST_IDLE:      if (w_start_mem) r_state <= ST_REQ;
        ST_REQ:       if (dmem_ready)
                        r_state <= (ex_is_load & ~dmem_rvalid) ? ST_WAIT_RESP : ST_IDLE;
        ST_WAIT_RESP: if (dmem_rvalid) r_state <= ST_IDLE;
        default:      r_state <= ST_IDLE;
      endcase
      if (w_done) begin
        r_wb_valid          <= 1'b1;
        r_wb.pc             <= ex_pc;
        r_wb.alu_result     <= ex_alu_result;
        r_wb.r_data         <= w_done_load ? w_load_data : '0;
        r_wb.is_load        <= w_done_load;
        r_wb.rdCtrl.wEnable <= ex_rd_wen & ~w_trap;
        r_wb.rdCtrl.rdAddr  <= ex_rd_addr;
        r_wb_misaligned     <= w_trap;
      end
    end
  end

  assign dmem_req   = (r_state == ST_REQ);
  assign dmem_we    = ex_is_store & ~ex_is_load;
  assign dmem_addr  = {ex_alu_result[XLEN-1:2], 2'b00};
  assign dmem_wdata = w_wdata;
  assign dmem_be    = w_be;

  assign wb_valid      = r_wb_valid;
  assign wb_pc         = r_wb.pc;
  assign wb_alu_result = r_wb.alu_result;
  assign wb_r_data     = r_wb.r_data;
  assign wb_is_load    = r_wb.is_load;
  assign wb_rd_wen     = r_wb.rdCtrl.wEnable & r_wb_valid;
  assign wb_rd_addr    = r_wb.rdCtrl.rdAddr;
  assign wb_misaligned = r_wb_misaligned;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed scenarios plus
// randomized transactions against an arithmetic reference model.
module tb_memory_access_stage;
  import memory_access_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_is_load, ex_is_store, ex_mem_unsigned, ex_rd_wen;
  logic [31:0] ex_pc, ex_alu_result, ex_store_data;
  logic [1:0]  ex_mem_size;
  logic [4:0]  ex_rd_addr;
  logic        stall_out, dmem_req, dmem_we, dmem_ready, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_is_load, wb_rd_wen, wb_misaligned;
  logic [31:0] wb_pc, wb_alu_result, wb_r_data;
  logic [4:0]  wb_rd_addr;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  memory_access_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_mem_size(ex_mem_size),
    .ex_mem_unsigned(ex_mem_unsigned), .ex_rd_wen(ex_rd_wen), .ex_rd_addr(ex_rd_addr),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_alu_result(wb_alu_result),
    .wb_r_data(wb_r_data), .wb_is_load(wb_is_load), .wb_rd_wen(wb_rd_wen),
    .wb_rd_addr(wb_rd_addr), .wb_misaligned(wb_misaligned), .dbg_state(dbg_state)
  );

  // Clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Reference model: plain arithmetic on byte offsets
  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
    int unsigned off = addr % 4;
    case (size)
      2'd0:    return 4'(1 << off);
      2'd1:    return 4'(3 << (2 * (off / 2)));
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'd0:    return (d & 32'hFF) * 32'h01010101;
      2'd1:    return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic [31:0] addr,
                                             input logic uns, input logic [31:0] rdata);
    int unsigned off = addr % 4;
    longint v;
    case (size)
      2'd0: begin
        v = longint'((rdata >> (8 * off)) & 32'hFF);
        if (!uns && v >= 128) v = v - 256;
      end
      2'd1: begin
        v = longint'((rdata >> (16 * (off / 2))) & 32'hFFFF);
        if (!uns && v >= 32768) v = v - 65536;
      end
      default: v = longint'(rdata);
    endcase
    return v[31:0];
  endfunction

  function automatic logic model_trap(input int kind, input logic [1:0] size, input logic [31:0] addr);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    if (kind == 0) return 1'b0;
    if (size == 2'd1) return (addr % 2) != 0;
    if (size == 2'd2) return (addr % 4) != 0;
    return 1'b0;
`else
    return (kind < 0) && (size == 2'd3) && (addr == 32'hFFFF_FFFF);
`endif
  endfunction

  // Driver: one instruction, kind 0=alu 1=load 2=store.
  // rdy_dly = wait cycles before ready; rv_dly = cycles from accept to rvalid (0 = same cycle).
  task automatic run_txn(input int kind, input logic [31:0] pc, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] rdata,
                         input logic [1:0] size, input logic uns, input logic rwen,
                         input logic [4:0] rd, input int rdy_dly, input int rv_dly);
    logic        trap;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_be;
    logic        exp_stall_acc;
    trap      = model_trap(kind, size, addr);
    exp_addr  = addr & 32'hFFFF_FFFC;
    exp_be    = model_be(size, addr);
    exp_wdata = model_wdata(size, sdata);
    exp_rdata = (kind == 1 && !trap) ? model_load(size, addr, uns, rdata) : 32'd0;
    @(negedge clk);
    ex_valid = 1'b1; ex_pc = pc; ex_alu_result = addr; ex_store_data = sdata;
    ex_is_load = (kind == 1); ex_is_store = (kind == 2); ex_mem_size = size;
    ex_mem_unsigned = uns; ex_rd_wen = rwen; ex_rd_addr = rd;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
    #1;
    if (kind == 0 || trap) begin
      checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL stall_nomem: got %b exp 0", stall_out); end
      checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL req_nomem: got %b exp 0", dmem_req); end
    end else begin
      checks++; if (stall_out !== 1'b1) begin failures++; $display("FAIL stall_issue: got %b exp 1", stall_out); end
      @(posedge clk);
      for (int i = 0; i < rdy_dly; i++) begin
        @(negedge clk); #1;
        checks++; if (dmem_req !== 1'b1 || dmem_addr !== exp_addr || dmem_be !== exp_be || dmem_we !== (kind == 2))
          begin failures++; $display("FAIL req_hold: got req=%b addr=%h be=%b we=%b exp req=1 addr=%h be=%b we=%b",
                                     dmem_req, dmem_addr, dmem_be, dmem_we, exp_addr, exp_be, kind == 2); end
        if (kind == 2) begin
          checks++; if (dmem_wdata !== exp_wdata) begin failures++; $display("FAIL wdata_hold: got %h exp %h", dmem_wdata, exp_wdata); end
        end
        checks++; if (stall_out !== 1'b1 || wb_valid !== 1'b0 || wb_rd_wen !== 1'b0)
          begin failures++; $display("FAIL bubble_req: got stall=%b wb_valid=%b rd_wen=%b exp 1 0 0", stall_out, wb_valid, wb_rd_wen); end
      end
      @(negedge clk);
      dmem_ready = 1'b1;
      if (kind == 1 && rv_dly == 0) begin dmem_rvalid = 1'b1; dmem_rdata = rdata; end
      #1;
      exp_stall_acc = (kind == 1 && rv_dly != 0);
      checks++; if (dmem_req !== 1'b1 || dmem_addr !== exp_addr || dmem_be !== exp_be || dmem_we !== (kind == 2))
        begin failures++; $display("FAIL req_accept: got req=%b addr=%h be=%b we=%b exp req=1 addr=%h be=%b we=%b",
                                   dmem_req, dmem_addr, dmem_be, dmem_we, exp_addr, exp_be, kind == 2); end
      if (kind == 2) begin
        checks++; if (dmem_wdata !== exp_wdata) begin failures++; $display("FAIL wdata: got %h exp %h", dmem_wdata, exp_wdata); end
      end
      checks++; if (stall_out !== exp_stall_acc) begin failures++; $display("FAIL stall_accept: got %b exp %b", stall_out, exp_stall_acc); end
      if (kind == 1 && rv_dly != 0) begin
        @(posedge clk);
        @(negedge clk);
        dmem_ready = 1'b0;
        for (int i = 1; i < rv_dly; i++) begin
          dmem_rdata = $urandom;
          #1;
          checks++; if (dmem_req !== 1'b0 || stall_out !== 1'b1 || wb_valid !== 1'b0)
            begin failures++; $display("FAIL wait_resp: got req=%b stall=%b wb_valid=%b exp 0 1 0", dmem_req, stall_out, wb_valid); end
          @(negedge clk);
        end
        dmem_rvalid = 1'b1; dmem_rdata = rdata;
        #1;
        checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL stall_rvalid: got %b exp 0", stall_out); end
      end
    end
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL wb_valid: got %b exp 1", wb_valid); end
    checks++; if (wb_pc !== pc || wb_alu_result !== addr)
      begin failures++; $display("FAIL wb_pc_alu: got pc=%h alu=%h exp pc=%h alu=%h", wb_pc, wb_alu_result, pc, addr); end
    checks++; if (wb_r_data !== exp_rdata) begin failures++; $display("FAIL wb_r_data: got %h exp %h", wb_r_data, exp_rdata); end
    checks++; if (wb_is_load !== (kind == 1 && !trap)) begin failures++; $display("FAIL wb_is_load: got %b exp %b", wb_is_load, kind == 1 && !trap); end
    checks++; if (wb_rd_wen !== (rwen && !trap) || wb_rd_addr !== rd)
      begin failures++; $display("FAIL wb_rd: got wen=%b addr=%0d exp wen=%b addr=%0d", wb_rd_wen, wb_rd_addr, rwen && !trap, rd); end
    checks++; if (wb_misaligned !== trap) begin failures++; $display("FAIL wb_misaligned: got %b exp %b", wb_misaligned, trap); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL state_done: got %0d exp IDLE", dbg_state); end
    dmem_ready = 1'b0; dmem_rvalid = 1'b0;
  endtask

  task automatic go_idle();
    @(negedge clk);
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0;
  endtask

  // Scenario tasks
  task automatic test_reset();
    rst = 1'b1; ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0; ex_pc = '0;
    ex_alu_result = '0; ex_store_data = '0; ex_mem_size = '0; ex_mem_unsigned = 1'b0;
    ex_rd_wen = 1'b0; ex_rd_addr = '0; dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (wb_valid !== 1'b0 || wb_rd_wen !== 1'b0 || wb_is_load !== 1'b0 || wb_misaligned !== 1'b0)
      begin failures++; $display("FAIL reset_flags: got v=%b wen=%b ld=%b mis=%b exp 0", wb_valid, wb_rd_wen, wb_is_load, wb_misaligned); end
    checks++; if (wb_pc !== 32'd0 || wb_alu_result !== 32'd0 || wb_r_data !== 32'd0 || wb_rd_addr !== 5'd0)
      begin failures++; $display("FAIL reset_data: got pc=%h alu=%h rd=%h addr=%0d exp 0", wb_pc, wb_alu_result, wb_r_data, wb_rd_addr); end
    checks++; if (dmem_req !== 1'b0 || stall_out !== 1'b0 || dbg_state !== ST_IDLE)
      begin failures++; $display("FAIL reset_ctrl: got req=%b stall=%b state=%0d exp 0 0 IDLE", dmem_req, stall_out, dbg_state); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_alu_op();
    run_txn(0, 32'h100, 32'h1234, 32'h0, 32'h0, 2'd2, 1'b0, 1'b1, 5'd5, 0, 0);
  endtask

  task automatic test_store_byte();
    run_txn(2, 32'h104, 32'h2003, 32'h0000_00AB, 32'h0, 2'd0, 1'b0, 1'b0, 5'd0, 2, 0);
  endtask

  task automatic test_load_byte();
    run_txn(1, 32'h108, 32'h1001, 32'h0, 32'h0000_F300, 2'd0, 1'b0, 1'b1, 5'd7, 0, 3);
  endtask

  task automatic test_lhu_zero_wait();
    run_txn(1, 32'h10C, 32'h1002, 32'h0, 32'h8001_0000, 2'd1, 1'b1, 1'b1, 5'd9, 0, 0);
  endtask

  task automatic test_idle_hold();
    go_idle();
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b0 || wb_rd_wen !== 1'b0)
      begin failures++; $display("FAIL idle_ctrl: got v=%b wen=%b exp 0 0", wb_valid, wb_rd_wen); end
    checks++; if (wb_pc !== 32'h10C || wb_r_data !== 32'h0000_8001 || wb_rd_addr !== 5'd9)
      begin failures++; $display("FAIL idle_hold: got pc=%h rd=%h addr=%0d exp 10c 00008001 9", wb_pc, wb_r_data, wb_rd_addr); end
  endtask

  task automatic test_reset_mid_txn();
    @(negedge clk);
    ex_valid = 1'b1; ex_pc = 32'h200; ex_alu_result = 32'h3000; ex_is_load = 1'b1; ex_is_store = 1'b0;
    ex_mem_size = 2'd2; ex_mem_unsigned = 1'b0; ex_rd_wen = 1'b1; ex_rd_addr = 5'd3;
    @(posedge clk);
    @(negedge clk); dmem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); dmem_ready = 1'b0; #1;
    checks++; if (dbg_state !== ST_WAIT_RESP) begin failures++; $display("FAIL mid_state: got %0d exp WAIT_RESP", dbg_state); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b0 || wb_pc !== 32'd0 || wb_r_data !== 32'd0 || dmem_req !== 1'b0 || dbg_state !== ST_IDLE)
      begin failures++; $display("FAIL mid_reset: got v=%b pc=%h rd=%h req=%b st=%0d exp zeros IDLE", wb_valid, wb_pc, wb_r_data, dmem_req, dbg_state); end
    @(negedge clk);
    rst = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL mid_stall: got %b exp 0", stall_out); end
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b0 || wb_r_data !== 32'd0 || dbg_state !== ST_IDLE)
      begin failures++; $display("FAIL stray_rvalid: got v=%b rd=%h st=%0d exp 0 0 IDLE", wb_valid, wb_r_data, dbg_state); end
    @(negedge clk); dmem_rvalid = 1'b0;
  endtask

  task automatic test_misalign_trap();
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    run_txn(1, 32'h300, 32'h1002, 32'h0, 32'h1234_5678, 2'd2, 1'b0, 1'b1, 5'd4, 0, 0);
`else
    // Without the trap a misaligned word proceeds with all lanes enabled.
    run_txn(1, 32'h300, 32'h1002, 32'h0, 32'h1234_5678, 2'd2, 1'b0, 1'b1, 5'd4, 1, 1);
`endif
  endtask

  task automatic test_back_to_back();
    int          kind;
    logic [1:0]  size;
    logic [31:0] addr;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      size = 2'($urandom_range(0, 2));
      addr = $urandom;
      run_txn(kind, $urandom, addr, $urandom, $urandom, size, 1'($urandom_range(0, 1)),
              (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
              $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) go_idle();
    end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_store_byte();
    test_load_byte();
    test_lhu_zero_wait();
    test_idle_hold();
    test_reset_mid_txn();
    test_misalign_trap();
    test_back_to_back();
    go_idle();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
